i2c_slave_regs: RTL and testbench

Synchronous, parametrised successor to the async I2C slave.
- Samples SCL/SDA with the system clock and detects START, repeated START and STOP.
- Decodes a 7-bit address and serves an external byte-wide register bank through a pointer that auto-increments and wraps.
- Drives open-drain enables for SDA/SCL; sits between the I2C pads and a local register file.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 51 +++++
 rtl/i2c_slave_regs.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the synchronous I2C register slave.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge detection and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so no edge or condition fires out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// Synchronous I2C slave serving a byte-wide register bank via an auto-incrementing pointer.
// Optional clock stretching with reg_ready handshake: define I2C_CLK_STRETCH_EN.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter  int unsigned DEPTH       = 16,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [6:0]    s_addr,
  input  logic          scl_in,
  input  logic          sda_in,
`ifdef I2C_CLK_STRETCH_EN
  input  logic          reg_ready,
`endif
  output logic          scl_oe,
  output logic          sda_oe,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [7:0]    reg_rdata,
  output logic          busy,
  output logic          stop_evt
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic ready;

`ifdef I2C_CLK_STRETCH_EN
  assign ready = reg_ready;
`else
  assign ready = 1'b1;
`endif

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sda_oe_q, sda_oe_d;
  logic            scl_oe_q, scl_oe_d;
  logic [AW-1:0]   reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic            reg_we_q, reg_we_d;
  logic            reg_re_q, reg_re_d;
  logic            busy_q, busy_d;
  logic            stop_evt_q, stop_evt_d;
  logic [7:0]      shift_in;

  assign shift_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q & ~ready;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    stop_evt_d  = 1'b0;

    if (stop_det) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      cnt_d      = 3'd7;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_evt_d = busy_q;
    end else if (start_det) begin
      state_d  = ADDR;
      phase_d  = 1'b0;
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd7;
            if (enable && shift_in[7:1] == s_addr) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end

        // phase 0 waits for the fall that opens the ACK slot, phase 1 closes it.
        // Reads leave on the rise inside the slot so the first data byte is loaded in time.
        ADDR_ACK: begin
          if (!phase_q) begin
            if (scl_fall) begin
              sda_oe_d = 1'b1;
              scl_oe_d = ~ready;
              phase_d  = 1'b1;
            end
          end else if (shift_q[0] == RW_READ) begin
            if (scl_rise) begin
              state_d = RD_LOAD;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = WR_PTR;
          end
        end

        WR_PTR, WR_DATA: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd7;
            if (!enable) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else if (state_q == WR_PTR) begin
              ptr_d   = shift_in[AW-1:0];
              state_d = PTR_ACK;
            end else begin
              reg_we_d    = 1'b1;
              reg_addr_d  = ptr_q;
              reg_wdata_d = shift_in;
              state_d     = WR_ACK;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end

        PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            scl_oe_d = ~ready;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = WR_DATA;
            if (state_q == WR_ACK) ptr_d = ptr_q + AW'(1);
          end
        end

        RD_LOAD: begin
          if (!phase_q) begin
            reg_re_d   = 1'b1;
            reg_addr_d = ptr_q;
            phase_d    = 1'b1;
          end else if (ready) begin
            shift_d  = reg_rdata;
            state_d  = RD_DATA;
            phase_d  = 1'b0;
            scl_oe_d = 1'b0;
            // If SCL already fell while waiting, bit 7 is due now rather than on the next fall.
            if (!scl_s) begin
              sda_oe_d = ~reg_rdata[7];
              cnt_d    = 3'd6;
            end else begin
              cnt_d = 3'd7;
            end
          end else begin
            scl_oe_d = ~scl_s;
          end
        end

        RD_DATA: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ~shift_q[cnt_q];
            if (cnt_q == 3'd0) phase_d = 1'b1;
            else               cnt_d   = cnt_q - 3'd1;
          end else begin
            sda_oe_d = 1'b0;
            scl_oe_d = ~ready;
            phase_d  = 1'b0;
            cnt_d    = 3'd7;
            state_d  = RD_ACK;
          end
        end

        RD_ACK: if (scl_rise) begin
          if (sda_s == ACK && enable) begin
            ptr_d   = ptr_q + AW'(1);
            state_d = RD_LOAD;
            phase_d = 1'b0;
          end else begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= 3'd7;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      stop_evt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      stop_evt_q  <= stop_evt_d;
    end
  end

  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign stop_evt  = stop_evt_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master plus a small register-bank model.
module tb_i2c_slave_regs;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [6:0] s_addr = 7'h50;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in, scl_oe, sda_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy, stop_evt;
  logic       reg_ready = 1'b1;

  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(
    .DEPTH(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .s_addr   (s_addr),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
`ifdef I2C_CLK_STRETCH_EN
    .reg_ready(reg_ready),
`endif
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .stop_evt (stop_evt)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [16];
  logic [3:0] we_addr [$];
  logic [7:0] we_data [$];
  logic [3:0] re_addr [$];
  int stop_cnt = 0, sda_cnt = 0, busy_cnt = 0;

  // Register bank model and event monitors.
  always @(negedge clk) begin
    if (reg_re) begin
      reg_rdata <= mem[reg_addr];
      re_addr.push_back(reg_addr);
    end
    if (reg_we) begin
      we_addr.push_back(reg_addr);
      we_data.push_back(reg_wdata);
    end
    if (stop_evt) stop_cnt <= stop_cnt + 1;
    if (sda_oe)   sda_cnt  <= sda_cnt + 1;
    if (busy)     busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    scl_m = 1'b1;
    for (int i = 0; i < 400 && scl_in !== 1'b1; i++) @(negedge clk);
    if (scl_in !== 1'b1) begin
      tests++; fails++;
      $display("FAIL scl_release: scl_in=%b, required 1", scl_in);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    q_wait();
    scl_high();
    q_wait();
    s = sda_in;
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(ack, s);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    q_wait();
    scl_high();
    q_wait();
    sda_m = 1'b0;
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    q_wait();
    scl_high();
    q_wait();
    sda_m = 1'b1;
    q_wait();
    q_wait();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({scl_oe, sda_oe, reg_we, reg_re, busy, stop_evt, reg_addr, reg_wdata} !== 18'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0",
               {scl_oe, sda_oe, reg_we, reg_re, busy, stop_evt, reg_addr, reg_wdata});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({scl_oe, sda_oe, busy} !== 3'b000) begin
      fails++;
      $display("FAIL post_reset_idle: got %b, required 000", {scl_oe, sda_oe, busy});
    end
  endtask

  task automatic test_write();
    logic a;
    int wb = we_addr.size();
    int sb = stop_cnt;
    logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'hA5, 8'h5A};
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], a);
      tests++;
      if (a !== 1'b0) begin
        fails++;
        $display("FAIL wr_ack[%0d]: got %b, required 0", i, a);
      end
    end
    i2c_stop();
    tests++;
    if (we_addr.size() != wb + 2) begin
      fails++;
      $display("FAIL wr_we_count: got %0d, required 2", we_addr.size() - wb);
    end else begin
      tests++;
      if ({we_addr[wb], we_data[wb]} !== {4'h3, 8'hA5}) begin
        fails++;
        $display("FAIL wr_first: got addr %h data %h, required 3 a5", we_addr[wb], we_data[wb]);
      end
      tests++;
      if ({we_addr[wb+1], we_data[wb+1]} !== {4'h4, 8'h5A}) begin
        fails++;
        $display("FAIL wr_second: got addr %h data %h, required 4 5a", we_addr[wb+1], we_data[wb+1]);
      end
    end
    tests++;
    if (stop_cnt - sb != 1) begin
      fails++;
      $display("FAIL wr_stop_evt: got %0d pulses, required 1", stop_cnt - sb);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_busy_after_stop: got %b, required 0", busy);
    end
  endtask

  task automatic test_read_wrap();
    logic a;
    logic [7:0] d;
    int rb = re_addr.size();
    logic [7:0] exp_d [3] = '{8'hC3, 8'h96, 8'h5E};
    logic [3:0] exp_a [3] = '{4'hE, 4'hF, 4'h0};
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h0E, a);
    tests++;
    if (a !== 1'b0) begin
      fails++;
      $display("FAIL rd_ptr_ack: got %b, required 0", a);
    end
    i2c_start();
    send_byte(8'hA1, a);
    tests++;
    if (a !== 1'b0) begin
      fails++;
      $display("FAIL rd_addr_ack: got %b, required 0", a);
    end
    for (int i = 0; i < 3; i++) begin
      recv_byte(i == 2, d);
      tests++;
      if (d !== exp_d[i]) begin
        fails++;
        $display("FAIL rd_data[%0d]: got %h, required %h", i, d, exp_d[i]);
      end
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({sda_oe, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rd_release_after_nack: sda_oe,busy=%b, required 00", {sda_oe, busy});
    end
    i2c_stop();
    tests++;
    if (re_addr.size() != rb + 3) begin
      fails++;
      $display("FAIL rd_re_count: got %0d, required 3", re_addr.size() - rb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (re_addr[rb+i] !== exp_a[i]) begin
          fails++;
          $display("FAIL rd_re_addr[%0d]: got %h, required %h", i, re_addr[rb+i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    logic a;
    int sc = sda_cnt, bc = busy_cnt;
    int strobes = we_addr.size() + re_addr.size();
    i2c_start();
    send_byte(8'hA2, a);
    tests++;
    if (a !== 1'b1) begin
      fails++;
      $display("FAIL mm_addr_nack: got %b, required 1", a);
    end
    send_byte(8'h00, a);
    i2c_stop();
    tests++;
    if (sda_cnt != sc || busy_cnt != bc) begin
      fails++;
      $display("FAIL mm_quiet: sda_oe cycles %0d busy cycles %0d, required 0 0", sda_cnt - sc, busy_cnt - bc);
    end
    tests++;
    if (we_addr.size() + re_addr.size() != strobes) begin
      fails++;
      $display("FAIL mm_strobes: got %0d, required 0", we_addr.size() + re_addr.size() - strobes);
    end
  endtask

  task automatic test_disabled();
    logic a;
    int wb = we_addr.size();
    enable = 1'b0;
    i2c_start();
    send_byte(8'hA0, a);
    tests++;
    if (a !== 1'b1) begin
      fails++;
      $display("FAIL dis_nack: got %b, required 1", a);
    end
    send_byte(8'h11, a);
    i2c_stop();
    tests++;
    if (we_addr.size() != wb) begin
      fails++;
      $display("FAIL dis_no_we: got %0d writes, required 0", we_addr.size() - wb);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic a, s;
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h05, a);
    i2c_start();
    send_byte(8'hA1, a);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    sda_m = 1'b1;
    q_wait();
    scl_high();
    q_wait();
    tests++;
    if (sda_oe !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_driving: sda_oe=%b, required 1", sda_oe);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({sda_oe, scl_oe, busy} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_release: sda_oe,scl_oe,busy=%b, required 000", {sda_oe, scl_oe, busy});
    end
    scl_m = 1'b0;
    sda_m = 1'b1;
    q_wait();
    rst = 1'b0;
    q_wait();
    i2c_start();
    send_byte(8'hA0, a);
    tests++;
    if (a !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_reack: got %b, required 0", a);
    end
    i2c_stop();
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    logic a, s;
    int low = 0;
    int wb = we_addr.size();
    logic [7:0] b = 8'h3C;
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h02, a);
    reg_ready = 1'b0;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (scl_oe !== 1'b1) low++;
    end
    tests++;
    if (low != 0) begin
      fails++;
      $display("FAIL stretch_hold: scl_oe low for %0d of 50 cycles, required 0", low);
    end
    reg_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (scl_oe !== 1'b0) begin
      fails++;
      $display("FAIL stretch_release: scl_oe=%b, required 0", scl_oe);
    end
    clk_bit(1'b1, a);
    tests++;
    if (a !== 1'b0) begin
      fails++;
      $display("FAIL stretch_ack: got %b, required 0", a);
    end
    i2c_stop();
    tests++;
    if (we_addr.size() != wb + 1 || we_addr[wb] !== 4'h2 || we_data[wb] !== 8'h3C) begin
      fails++;
      $display("FAIL stretch_we: got %0d writes, required 1 write of 3c at 2", we_addr.size() - wb);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h3C ^ 8'(i);
    mem[5]  = 8'h00;
    mem[14] = 8'hC3;
    mem[15] = 8'h96;
    mem[0]  = 8'h5E;
    test_reset();
    test_write();
    test_read_wrap();
    test_mismatch();
    test_disabled();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
